pc_fetch_seq: RTL
=================

Name: pc_fetch_seq

Overview:
- Sequencing controller for the program counter register and instruction-memory fetch port of the multicycle MIPS core.
- Owns the architectural PC and issues fetch requests to instruction memory with a req/ack handshake.
- Delivers fetched PCs to decode through a one-entry valid/ready buffer.
- Applies branch/jump redirects and discards responses that are in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0380, redirect target for a misaligned redirect (only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- redirect  in  1  one-cycle pulse: branch taken / jump / jr resolved.
- redirect_pc  in  32  target PC, sampled when redirect=1.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  memory accepted and completed the request this cycle.
- if_valid  out  1  output buffer holds a valid fetched PC.
- if_pc  out  32  PC of the buffered fetch.
- if_ready  in  1  decode consumes the buffer when if_valid=1.
- misalign_exc  out  1  one-cycle pulse: misaligned redirect (feature only).
- misalign_addr  out  32  last offending redirect_pc (feature only).

Behaviour:
- Reset is asynchronous on rst_n=0:
  - pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, if_valid=0, if_pc=0.
  - misalign_exc=0, misalign_addr=0.
  - State goes to BOOT.
- Reset mid-transaction abandons the outstanding request; no response is accepted after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: BOOT, REQ, KILL, FULL.
- BOOT:
  - imem_req=0.
  - Next cycle goes to REQ with imem_addr=pc.
  - A redirect in BOOT loads pc first.
- REQ:
  - imem_req=1, imem_addr holds the captured PC.
  - ack=1, redirect=0: if_valid<=1, if_pc<=imem_addr, pc<=imem_addr+4, imem_req<=0 → FULL.
  - ack=1, redirect=1: response is discarded, pc<=redirect_pc, imem_addr<=redirect_pc, stay REQ (new request next cycle).
  - ack=0, redirect=1: pc<=redirect_pc, imem_addr unchanged → KILL.
- KILL:
  - imem_req stays 1 with the old address until ack.
  - On ack: response discarded, imem_addr<=pc → REQ.
  - A further redirect in KILL overwrites pc and stays KILL.
  - A redirect coinciding with ack: pc<=redirect_pc → REQ with the new pc.
- FULL:
  - imem_req=0; if_valid=1 is held until if_ready=1.
  - if_ready=1, redirect=0: if_valid<=0, imem_addr<=pc → REQ.
  - redirect=1 (with or without if_ready): if_valid<=0 (flush), pc<=redirect_pc, imem_addr<=redirect_pc → REQ.
- Redirect has priority over sequential increment in every state.
- Latency: request to if_valid is 1 cycle after ack. Peak throughput is one fetch per 2 cycles (REQ/FULL alternation with ack and if_ready both 1).
- pc+4 is computed modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Without the feature, redirect_pc[1:0] is forced to 2'b00 when loaded.
- if_pc never reports a discarded (killed) fetch.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc<=EXC_VECTOR instead of the target.
  - misalign_exc pulses 1 cycle (registered, the cycle after redirect).
  - misalign_addr<=redirect_pc.
  - State transitions are identical to a normal redirect.
- Undefined: misalign_exc and misalign_addr are tied to 0, and low bits are truncated as described in Behaviour.

Test Plan:
- Release rst_n, ack every request 1 cycle later, if_ready=1 → if_pc sequence 0x0,0x4,0x8,0xC with if_valid pulses every 2 cycles; imem_req=0 in BOOT.
- Hold if_ready=0 for 5 cycles after first fetch → if_valid and if_pc=0x0 stable, imem_req=0 throughout; release → next request addr 0x4.
- Request to 0x10 outstanding with ack delayed 3 cycles, redirect to 0x100 in the 1st wait cycle → imem_addr stays 0x10 until ack, that response is discarded (no if_valid), next request addr 0x100.
- Redirect to 0x200 in the same cycle as ack, and separately in FULL with if_ready=1 → buffer flushed/response dropped, next if_pc=0x200, no stale PC delivered.
- pc=0xFFFF_FFFC fetched → next request addr 0x0000_0000.
- With PC_ALIGN_CHECK_EN, redirect to 0x102 → misalign_exc one pulse, misalign_addr=0x102, next if_pc=0x380. Without the macro → next if_pc=0x100. Assert rst_n=0 mid-KILL → all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_fetch_seq.sv
// PC owner and instruction-fetch sequencer: req/ack fetch port, one-entry decode buffer.
// Optional misaligned-redirect trap enabled with `define PC_ALIGN_CHECK_EN.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        if_valid,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);

    typedef enum logic [1:0] {StBoot, StReq, StKill, StFull} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] redir_tgt;

`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
    logic        exc_q, exc_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    assign misaligned = |redirect_pc[1:0];
    assign redir_tgt  = misaligned ? EXC_VECTOR : redirect_pc;

    always_comb begin
        exc_d      = redirect && misaligned;
        mis_addr_d = mis_addr_q;
        if (redirect && misaligned) begin
            mis_addr_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q      <= 1'b0;
            mis_addr_q <= 32'h0;
        end else begin
            exc_q      <= exc_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign misalign_exc  = exc_q;
    assign misalign_addr = mis_addr_q;
`else
    logic unused_cfg;

    // Targets are word-aligned by truncation; the trap vector is not used.
    assign redir_tgt     = {redirect_pc[31:2], 2'b00};
    assign unused_cfg    = ^{redirect_pc[1:0], EXC_VECTOR};
    assign misalign_exc  = 1'b0;
    assign misalign_addr = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if_pc_d = if_pc_q;
        unique case (state_q)
            StBoot: begin
                if (redirect) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end else begin
                    addr_d = pc_q;
                end
                state_d = StReq;
            end
            StReq: begin
                if (redirect) begin
                    pc_d = redir_tgt;
                    if (imem_ack) begin
                        addr_d = redir_tgt;
                    end else begin
                        // Old request must still complete; its response is dropped in KILL.
                        state_d = StKill;
                    end
                end else if (imem_ack) begin
                    valid_d = 1'b1;
                    if_pc_d = addr_q;
                    pc_d    = addr_q + 32'd4;
                    state_d = StFull;
                end
            end
            StKill: begin
                if (redirect) begin
                    pc_d = redir_tgt;
                end
                if (imem_ack) begin
                    addr_d  = redirect ? redir_tgt : pc_q;
                    state_d = StReq;
                end
            end
            StFull: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redir_tgt;
                    addr_d  = redir_tgt;
                    state_d = StReq;
                end else if (if_ready) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    state_d = StReq;
                end
            end
            default: state_d = StBoot;
        endcase
        req_d = (state_d == StReq) || (state_d == StKill);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            if_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req && !imem_ack) |=> (imem_addr == $past(imem_addr)));
    a_req_xor_buf: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_req && if_valid));

endmodule
